// File: rtl/arrow_queue.sv
// Rhythm-game arrow queue: shifts arrows toward the head on each beat and judges button presses.
// Optional combo counter enabled by defining ARROW_QUEUE_COMBO_EN; otherwise combo is tied to 0.
//
// state  | meaning
// IDLE   | not in play; beat and buttons ignored, slots hold rest
// ARMED  | head arrow awaiting a press or the next beat
// JUDGED | press already judged this beat; further presses ignored
module arrow_queue #(
  parameter int DEPTH   = 4,
  parameter int ARROW_W = 4,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat,
  input  logic                     playing,
  input  logic [ARROW_W-1:0]       arrow_in,
  input  logic [3:0]               btn,
  output logic [DEPTH*ARROW_W-1:0] queue_out,
  output logic                     hit,
  output logic                     miss,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       combo
);

  localparam logic [ARROW_W-1:0] CODE_UP    = ARROW_W'(10);
  localparam logic [ARROW_W-1:0] CODE_RIGHT = ARROW_W'(13);
  localparam logic [ARROW_W-1:0] CODE_REST  = ARROW_W'(14);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    JUDGED
  } state_t;

  state_t             state;
  logic [ARROW_W-1:0] slot_q [DEPTH];

  logic [ARROW_W-1:0] arrow_san;
  logic [ARROW_W-1:0] head_dir;
  logic [3:0]         head_mask;
  logic               head_rest;
  logic               press_ok;
  logic               stop_evt;
  logic               beat_evt;
  logic               press_evt;
  logic               hit_evt;
  logic               miss_evt;

  always_comb begin
    arrow_san = CODE_REST;
    if (arrow_in >= CODE_UP && arrow_in <= CODE_RIGHT) arrow_san = arrow_in;
  end

  // A correct press is exactly the one-hot bit selected by the head direction.
  always_comb begin
    head_dir  = slot_q[0] - CODE_UP;
    head_mask = 4'b0001 << head_dir[1:0];
    head_rest = (slot_q[0] == CODE_REST);
    press_ok  = !head_rest && (btn == head_mask);
  end

  always_comb begin
    stop_evt  = (state != IDLE) && !playing;
    beat_evt  = (state != IDLE) && playing && beat;
    press_evt = (state == ARMED) && playing && !beat && (btn != 4'b0000);
    hit_evt   = press_evt && press_ok;
    miss_evt  = (beat_evt && (state == ARMED) && !head_rest) || (press_evt && !press_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hit   <= 1'b0;
      miss  <= 1'b0;
      score <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= CODE_REST;
    end else begin
      hit  <= hit_evt;
      miss <= miss_evt;
      if (hit_evt && score != SCORE_MAX) score <= score + 1'b1;
      case (state)
        IDLE: begin
          if (playing) state <= ARMED;
        end
        ARMED, JUDGED: begin
          if (stop_evt) begin
            state <= IDLE;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= CODE_REST;
          end else if (beat_evt) begin
            state <= ARMED;
            for (int i = 0; i < DEPTH - 1; i++) slot_q[i] <= slot_q[i+1];
            slot_q[DEPTH-1] <= arrow_san;
          end else if (press_evt) begin
            state <= JUDGED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARROW_QUEUE_COMBO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo <= '0;
    end else if (stop_evt || miss_evt) begin
      combo <= '0;
    end else if (hit_evt && combo != SCORE_MAX) begin
      combo <= combo + 1'b1;
    end
  end
`else
  assign combo = '0;
`endif

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign queue_out[g*ARROW_W +: ARROW_W] = slot_q[g];
  end

endmodule

// File: tb/tb_arrow_queue.sv
// Directed bench for arrow_queue: queue-based reference model checked every cycle plus literal pins.
module tb_arrow_queue;
  localparam int DEPTH   = 4;
  localparam int ARROW_W = 4;
  localparam int SCORE_W = 8;
  localparam int SMAX    = (1 << SCORE_W) - 1;
`ifdef ARROW_QUEUE_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic beat = 1'b0;
  logic playing = 1'b0;
  logic [ARROW_W-1:0] arrow_in = 4'd14;
  logic [3:0] btn = 4'b0000;
  logic [DEPTH*ARROW_W-1:0] queue_out;
  logic hit, miss;
  logic [SCORE_W-1:0] score, combo;

  int checks = 0;
  int errors = 0;

  arrow_queue #(.DEPTH(DEPTH), .ARROW_W(ARROW_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .beat(beat), .playing(playing), .arrow_in(arrow_in),
    .btn(btn), .queue_out(queue_out), .hit(hit), .miss(miss), .score(score), .combo(combo)
  );

  always #5 clk = ~clk;

  // Reference model: arrows as a FIFO, "judged" meaning one press was already taken this beat.
  int m_q[$];
  bit m_active, m_judged, m_hit, m_miss;
  int m_score, m_combo;

  function automatic int sanitize(input int a);
    return (a >= 10 && a <= 13) ? a : 14;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      repeat (DEPTH) m_q.push_back(14);
      m_active = 0; m_judged = 0; m_hit = 0; m_miss = 0; m_score = 0; m_combo = 0;
    end else begin
      m_hit = 0; m_miss = 0;
      if (!m_active) begin
        if (playing) begin m_active = 1; m_judged = 0; end
      end else if (!playing) begin
        m_active = 0;
        m_combo = 0;
        foreach (m_q[i]) m_q[i] = 14;
      end else if (beat) begin
        if (!m_judged && m_q[0] != 14) begin m_miss = 1; m_combo = 0; end
        void'(m_q.pop_front());
        m_q.push_back(sanitize(int'(arrow_in)));
        m_judged = 0;
      end else if (!m_judged && btn != 0) begin
        m_judged = 1;
        if (m_q[0] != 14 && $countones(btn) == 1 && btn[m_q[0] - 10]) begin
          m_hit = 1;
          if (m_score < SMAX) m_score++;
          if (m_combo < SMAX) m_combo++;
        end else begin
          m_miss = 1; m_combo = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DEPTH*ARROW_W-1:0] eq;
    eq = '0;
    for (int i = 0; i < DEPTH; i++) eq[i*ARROW_W +: ARROW_W] = ARROW_W'(m_q[i]);
    chk("model_queue", 64'(queue_out), 64'(eq));
    chk("model_hit", 64'(hit), 64'(m_hit));
    chk("model_miss", 64'(miss), 64'(m_miss));
    chk("model_score", 64'(score), 64'(m_score));
    chk("model_combo", 64'(combo), COMBO_EN ? 64'(m_combo) : 64'd0);
    chk("hit_miss_excl", 64'(hit & miss), 64'd0);
  end

  // Inputs change 1 time unit after a rising edge and are consumed at the next one.
  task automatic tick(input logic b, input logic [3:0] bn, input logic [3:0] a);
    @(posedge clk); #1;
    beat = b; btn = bn; arrow_in = a;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_queue", 64'(queue_out), 64'hEEEE);
    chk("rst_score", 64'(score), 64'd0);
    chk("rst_pulses", 64'({hit, miss}), 64'd0);
    rst = 1'b0;

    @(posedge clk); #1 playing = 1'b1;
    tick(0, 4'b0000, 4'd14);
    tick(1, 4'b0000, 4'd10);
    tick(1, 4'b0000, 4'd11);
    tick(1, 4'b0000, 4'd12);
    tick(1, 4'b0000, 4'd13);
    tick(0, 4'b0000, 4'd14);
    chk("fill_queue", 64'(queue_out), 64'hDCBA);
    chk("fill_score", 64'(score), 64'd0);

    tick(0, 4'b0001, 4'd14);
    tick(0, 4'b0000, 4'd14);
    chk("up_hit", 64'(hit), 64'd1);
    chk("up_score", 64'(score), 64'd1);
    chk("up_combo", 64'(combo), COMBO_EN ? 64'd1 : 64'd0);
    tick(0, 4'b0001, 4'd14);
    tick(0, 4'b0000, 4'd14);
    chk("second_press", 64'({hit, miss}), 64'd0);

    tick(1, 4'b0000, 4'd14);          // head -> 11, previous beat judged
    tick(0, 4'b0000, 4'd14);
    chk("judged_beat_nomiss", 64'(miss), 64'd0);
    tick(1, 4'b0000, 4'd14);          // head 11 never pressed
    tick(0, 4'b0000, 4'd14);
    chk("unpressed_miss", 64'(miss), 64'd1);
    tick(0, 4'b0011, 4'd14);          // head 12, two bits
    tick(0, 4'b0000, 4'd14);
    chk("multi_bit_miss", 64'(miss), 64'd1);
    chk("multi_bit_score", 64'(score), 64'd1);
    tick(1, 4'b0000, 4'd14);
    tick(0, 4'b1000, 4'd14);          // head 13, right
    tick(0, 4'b0000, 4'd14);
    chk("right_hit", 64'(hit), 64'd1);
    tick(1, 4'b0000, 4'd14);          // head becomes 14
    tick(1, 4'b0000, 4'd14);          // rest head unpressed
    tick(0, 4'b0000, 4'd14);
    chk("rest_no_miss", 64'(miss), 64'd0);
    tick(0, 4'b0100, 4'd14);          // press on rest head
    tick(0, 4'b0000, 4'd14);
    chk("rest_press_miss", 64'(miss), 64'd1);

    tick(1, 4'b0000, 4'd7);
    tick(0, 4'b0000, 4'd14);
    chk("sanitize_7", 64'(queue_out[15:12]), 64'd14);

    for (int i = 0; i < DEPTH; i++) tick(1, 4'b0000, 4'd10);
    for (int i = 0; i < 260; i++) begin
      tick(1, 4'b0000, 4'd10);
      tick(0, 4'b0001, 4'd10);
      tick(0, 4'b0000, 4'd10);
    end
    chk("sat_hit", 64'(hit), 64'd1);
    chk("sat_score", 64'(score), 64'd255);

    tick(1, 4'b0001, 4'd10);          // press together with beat
    tick(0, 4'b0000, 4'd10);
    chk("beat_priority", 64'({hit, miss}), 64'd0);

    @(posedge clk); #1 playing = 1'b0;
    @(posedge clk); #1;
    chk("stop_queue", 64'(queue_out), 64'hEEEE);
    chk("stop_score", 64'(score), 64'd255);
    chk("stop_combo", 64'(combo), 64'd0);

    playing = 1'b1;
    tick(0, 4'b0000, 4'd10);
    for (int i = 0; i < DEPTH; i++) tick(1, 4'b0000, 4'd10);
    tick(0, 4'b0001, 4'd10);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_hit", 64'(hit), 64'd0);
    chk("rst_mid_queue", 64'(queue_out), 64'hEEEE);
    chk("rst_mid_score", 64'(score), 64'd0);
    btn = 4'b0000;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 playing = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arrow_queue.md
ARROW_QUEUE -- requirements
Module: arrow_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued arrow slots (2..8).
REQ-002 SHALL have parameter ARROW_W, default 4, arrow code width.
REQ-003 SHALL have parameter SCORE_W, default 8, score/combo width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port beat  input  1  one-cycle metronome tick.
REQ-007 SHALL have port playing  input  1  high while game is in play state.
REQ-008 SHALL have port arrow_in  input  ARROW_W  next arrow code from random generator (10..14).
REQ-009 SHALL have port btn  input  4  press pulses, bit0 up, bit1 down, bit2 left, bit3 right.
REQ-010 SHALL have port queue_out  output  DEPTH*ARROW_W  slot contents, slot0 (head) in LSBs.
REQ-011 SHALL have port hit  output  1  one-cycle pulse, correct press.
REQ-012 SHALL have port miss  output  1  one-cycle pulse, wrong press or missed arrow.
REQ-013 SHALL have port score  output  SCORE_W  hit count.
REQ-014 SHALL have port combo  output  SCORE_W  consecutive hits.

Function
REQ-015 SHALL decode codes 10,11,12,13 as directions up,down,left,right (btn bit = code-10); code 14 and any other value SHALL be stored as 14 (rest).
REQ-016 SHALL implement FSM states IDLE, ARMED, JUDGED.
REQ-017 IDLE: on playing=1 SHALL go to ARMED next cycle; beat and btn ignored.
REQ-018 ARMED/JUDGED: on beat, SHALL shift slot[i]<=slot[i+1], load sanitized arrow_in into slot[DEPTH-1], enter ARMED.
REQ-019 Arrow sampled at beat SHALL reach slot0 after DEPTH-1 further beats.
REQ-020 On beat while state ARMED and slot0 non-rest, SHALL pulse miss the following cycle and clear combo.
REQ-021 In ARMED without beat, a cycle with btn!=0 SHALL be judged against slot0 and move to JUDGED.
REQ-022 Judge: btn one-hot matching slot0 direction -> hit pulse; otherwise (wrong bit, multiple bits, slot0 rest) -> miss pulse.
REQ-023 hit/miss SHALL be registered, asserted exactly one cycle after the judged press; never both high.
REQ-024 In JUDGED, further presses SHALL be ignored until next beat.
REQ-025 Press coinciding with beat SHALL be ignored; beat has priority.
REQ-026 hit SHALL increment score and combo, each saturating at 2^SCORE_W-1; miss SHALL zero combo, score unchanged.
REQ-027 playing falling to 0 SHALL go to IDLE next cycle, set all slots to 14, hold score, zero combo.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE, all slots 14, score 0, combo 0, hit 0, miss 0.
REQ-029 Reset mid-judgement SHALL suppress any pending hit/miss pulse.
REQ-030 After rst release, first active clock edge SHALL follow REQ-017.

Configuration
REQ-031 Macro ARROW_QUEUE_COMBO_EN defined: combo counter per REQ-026.
REQ-032 Macro ARROW_QUEUE_COMBO_EN undefined: no combo register; combo output constant 0; all else unchanged.

Verification
REQ-033 Reset, playing=1, 4 beats with arrow_in=10,11,12,13 -> queue_out=16'hDCBA, score=0.
REQ-034 Head=10 (up), btn=4'b0001 -> hit next cycle, score 0->1, combo 0->1; second press same beat -> no pulse.
REQ-035 Head=12, btn=4'b0011 -> miss, combo 5->0, score unchanged.
REQ-036 Head=11 not pressed, beat -> miss one cycle after beat; head=14 not pressed, beat -> no pulse.
REQ-037 score=255, hit -> score stays 255; arrow_in=7 on beat -> slot stored as 14.
REQ-038 rst asserted mid-play between press and pulse -> hit=0, queue all 14, score 0; build without ARROW_QUEUE_COMBO_EN -> combo=0 throughout REQ-034.
